// File: rtl/sb_prog_pkg.sv
// ============================================================================
// sb_prog_pkg : shared types and constants for the switch-block SRAM-bank programmer
// Revision 1.0
// ============================================================================
`default_nettype none

package sb_prog_pkg;

    localparam int NUM_MUX_DEF      = 18;
    localparam int BITS_PER_MUX_DEF = 2;
    localparam int MUX_IDX_W_DEF    = 5;
    localparam int ADDR_W_DEF       = 1 + MUX_IDX_W_DEF;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int FRAME_BITS_DEF = NUM_MUX_DEF * BITS_PER_MUX_DEF;
    localparam int CNT_W_DEF      = cnt_width(FRAME_BITS_DEF);

    // One-hot encoding so each status output is a single flop bit.
    localparam int IDLE_B   = 0;
    localparam int LOAD_B   = 1;
    localparam int SETUP_B  = 2;
    localparam int STROBE_B = 3;
    localparam int HOLD_B   = 4;
    localparam int DONE_B   = 5;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_LOAD   = 6'b000010,
        ST_SETUP  = 6'b000100,
        ST_STROBE = 6'b001000,
        ST_HOLD   = 6'b010000,
        ST_DONE   = 6'b100000
    } prog_state_e;

endpackage

`default_nettype wire

// File: rtl/sb_mem_bank_prog_if.sv
// ============================================================================
// sb_mem_bank_prog_if : bitstream handshake and SRAM-bank write bus
// Revision 1.0
// ============================================================================
`default_nettype none

interface sb_mem_bank_prog_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              abort;
    logic              bs_valid;
    logic              bs_data;
    logic              bs_ready;
    logic              enable;
    logic [0:ADDR_W-1] address;
    logic [0:0]        data_in;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, bs_valid, bs_data,
        input  bs_ready, enable, address, data_in, busy, done
    );

    modport slave (
        input  start, abort, bs_valid, bs_data,
        output bs_ready, enable, address, data_in, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/sb_prog_bit_counter.sv
// ============================================================================
// sb_prog_bit_counter : frame bit counter, saturating at the terminal count
// Revision 1.0
// ============================================================================
`default_nettype none

module sb_prog_bit_counter #(
    parameter int WIDTH    = 6,
    parameter int TERMINAL = 35
) (
    input  wire logic             prog_clk,
    input  wire logic             prog_reset_n,
    input  wire logic             clear,
    input  wire logic             incr,
    output logic [WIDTH-1:0]      count,
    output logic                  terminal
);

    assign terminal = (count == WIDTH'(TERMINAL));

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sb_mem_bank_prog.sv
// ============================================================================
// sb_mem_bank_prog : replays a serial bitstream as enable/address/data_in writes
// Revision 1.0
// ============================================================================
`default_nettype none

module sb_mem_bank_prog
    import sb_prog_pkg::*;
#(
    parameter int NUM_MUX      = NUM_MUX_DEF,
    parameter int BITS_PER_MUX = BITS_PER_MUX_DEF,
    parameter int MUX_IDX_W    = MUX_IDX_W_DEF,
    parameter int ADDR_W       = 1 + MUX_IDX_W
) (
    input  wire logic          prog_clk,
    input  wire logic          prog_reset_n,
    sb_mem_bank_prog_if.slave  bus
);

    localparam int FRAME_BITS = NUM_MUX * BITS_PER_MUX;
    localparam int CNT_W      = cnt_width(FRAME_BITS);

    prog_state_e          state;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_last;
    logic                 cnt_clear;
    logic                 cnt_incr;
    logic [MUX_IDX_W-1:0] mux_idx;

    assign cnt_clear = state[IDLE_B] && bus.start && !bus.abort;
    assign cnt_incr  = state[HOLD_B] && !bus.abort && !cnt_last;
    assign mux_idx   = MUX_IDX_W'(cnt >> 1);

    sb_prog_bit_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (FRAME_BITS - 1)
    ) u_bit_counter (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .clear        (cnt_clear),
        .incr         (cnt_incr),
        .count        (cnt),
        .terminal     (cnt_last)
    );

    // Status outputs are single one-hot flop bits, so they cannot glitch.
    assign bus.bs_ready = state[LOAD_B];
    assign bus.enable   = state[STROBE_B];
    assign bus.done     = state[DONE_B];
    assign bus.busy     = !state[IDLE_B];

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state       <= ST_IDLE;
            bus.address <= '0;
            bus.data_in <= '0;
        end else if (bus.abort && !state[IDLE_B]) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.bs_valid) begin
                        bus.data_in[0] <= bus.bs_data;
                        // address[0] selects the bit, address[1] is the mux-index MSB
                        bus.address    <= {cnt[0], mux_idx};
                        state          <= ST_SETUP;
                    end
                end
                ST_SETUP:  state <= ST_STROBE;
                ST_STROBE: state <= ST_HOLD;
                ST_HOLD:   state <= cnt_last ? ST_DONE : ST_LOAD;
                ST_DONE:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/sb_mem_bank_prog.md
# sb_mem_bank_prog

Configuration-side driver for the memory-bank-programmed unique switch blocks: accepts a serial bitstream over a valid/ready handshake and replays it as the `enable` / `address` / `data_in` write sequence that an `sb_*` block's decoder and `mux_*_mem` cells consume. It sits between the fabric-level bitstream loader and one switch block, and is the write initiator for that block's per-mux SRAM bank. One instance programs one full switch-block frame (NUM_MUX × BITS_PER_MUX bits) per `start`, then reports completion.

## Interface
- NUM_MUX, 18, routing muxes in the target switch block (decoder outputs)
- BITS_PER_MUX, 2, SRAM bits per mux; must be 2 (one address bit selects the bit)
- MUX_IDX_W, 5, width of mux-index field (decoder address width)
- ADDR_W, 6, total address width = 1 + MUX_IDX_W
- prog_clk  in  1  programming clock; all state on rising edge
- prog_reset_n  in  1  reset: asynchronous, active-low
- start  in  1  one-cycle request to program a frame; sampled in IDLE only
- abort  in  1  abandon current frame; highest priority after reset
- bs_valid  in  1  bitstream bit available
- bs_data  in  1  bitstream bit value
- bs_ready  out  1  bit accepted when bs_valid && bs_ready
- enable  out  1  decoder enable; high exactly one cycle per bit write
- address  out  [0:ADDR_W-1]  address[0] = bit-within-mux, address[1:ADDR_W-1] = mux index, address[1] MSB
- data_in  out  [0:0]  bit value being written
- busy  out  1  high from leaving IDLE until return to IDLE
- done  out  1  one-cycle pulse after last bit written

## Operation
- States: IDLE, LOAD, SETUP, STROBE, HOLD, DONE (package enum).
- IDLE: bs_ready=0, busy=0. `start`=1 → LOAD, bit counter cleared to 0.
- LOAD: bs_ready=1. On bs_valid: capture bs_data into data_in; address[0]=cnt[0], mux index=cnt>>1 → SETUP. No handshake → stay in LOAD (arbitrary gaps allowed).
- SETUP: enable=0, address/data_in stable → STROBE.
- STROBE: enable=1 for exactly this cycle → HOLD.
- HOLD: enable=0, address/data_in still stable. If cnt == NUM_MUX*BITS_PER_MUX-1 → DONE; else cnt+1 → LOAD.
- DONE: done=1, busy=1 → IDLE.
- Stream order: mux 0 bit 0, mux 0 bit 1, mux 1 bit 0, …, mux NUM_MUX-1 bit 1 (36 bits at defaults).
- Counter width ceil(log2(NUM_MUX*BITS_PER_MUX)); never exceeds terminal value, no wrap.
- `start` outside IDLE: ignored, no side effect.
- `abort` in any non-IDLE state: next state IDLE, enable forced 0 on the next edge, done not pulsed; a STROBE already registered completes that single cycle. abort && start in IDLE: stays IDLE.
- bs_valid while bs_ready=0: bit is not consumed; upstream must hold it.

## Timing
- All outputs registered; enable, bs_ready, busy, done decoded from registered one-hot state — glitch-free.
- Reset values: state IDLE, enable=0, address=0, data_in=0, bs_ready=0, busy=0, done=0, counter=0.
- Reset mid-frame: immediate asynchronous return to reset values; partial frame discarded.
- start at edge N → LOAD (bs_ready=1) at N+1. Bit accepted at edge M → SETUP M+1, STROBE M+2, HOLD M+3, LOAD M+4.
- Continuous bs_valid: 4 cycles/bit; default frame = 1 + 144 cycles, done at cycle 146 after start edge.
- address/data_in stable from SETUP through HOLD: ≥1 cycle setup and hold around enable.

## Structure
- Package `sb_prog_pkg`: state enum, NUM_MUX/BITS_PER_MUX defaults, frame-length and counter-width constants.
- One sub-module natural: `sb_prog_bit_counter` (clear, increment, terminal-count flag).
- FSM, address split and output registers in the top.

## Test plan
- Full frame, bs_valid held 1, bit k = k mod 3 == 0 → 36 enable pulses, pulse for bit 7 has address[0]=1, mux index 3, data_in=0; done at cycle 146.
- Random bs_valid gaps (0-5 cycles) → same write sequence, bs_ready high only in LOAD, no enable without a prior accepted bit.
- abort asserted during SETUP of bit 10 → no enable for bit 10, busy low next cycle, no done; new start reprograms from bit 0.
- prog_reset_n low during STROBE of bit 20 → enable, busy, bs_ready 0 asynchronously; all outputs at reset values.
- start pulsed during LOAD and HOLD → ignored; bit count and done timing unchanged.
- Scoreboard model of an 18×2 SRAM bank written on enable → final contents equal input frame.
